carbon_uart_rx_phy: RTL

- 8N1 asynchronous serial receiver and deserializer.
- Converts a raw serial line into a byte stream with a valid/ready handshake.
- Drives the uart_rx_valid / uart_rx_data / uart_rx_ready side of carbonio; it is the byte source that carbonio's RX port consumes.
- Sits between the board RX pin and carbonio in each system top. Bit timing comes from a run-time divisor.

---
 rtl/carbon_uart_pkg.sv | 19 +
 rtl/carbon_sync2.sv | 25 ++
 rtl/carbon_uart_rx_phy.sv | 177 +++++++++++++++++
 3 files changed

// File: rtl/carbon_uart_pkg.sv
// Shared types and constants for the carbon UART receive path.
// Imported by the RX PHY and by any logic that inspects its state.
package carbon_uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        BRK_WAIT
    } uart_rx_state_e;

    localparam int UART_DATA_BITS = 8;
    localparam int UART_MIN_DIV   = 4;

    // Bits needed for a bit index that must be able to hold UART_DATA_BITS itself.
    localparam int UART_BIT_IDX_W = $clog2(UART_DATA_BITS + 1);

endpackage

// File: rtl/carbon_sync2.sv
// Two-flop synchronizer for a single asynchronous input pin.
// The reset value is a parameter so idle-high and idle-low pins can share it.
module carbon_sync2 #(
    parameter logic RESET_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta;

    // NOTE: flops use non-blocking assignments so meta and q update together at the edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            meta <= RESET_VAL;
            q    <= RESET_VAL;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/carbon_uart_rx_phy.sv
// 8N1 serial receiver: synchronizes rx_in, times bits from a run-time divisor
// and hands bytes out through a single-entry valid/ready holding register.
module carbon_uart_rx_phy
    import carbon_uart_pkg::*;
#(
    parameter int DIV_W   = 16,
    parameter int MIN_DIV = UART_MIN_DIV
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      enable,
    input  logic [DIV_W-1:0]          baud_div,
    input  logic                      rx_in,
    output logic                      rx_valid,
    output logic [UART_DATA_BITS-1:0] rx_data,
    input  logic                      rx_ready,
    output logic                      frame_err,
    output logic                      overrun_err,
    output logic                      busy
);

    localparam logic [DIV_W-1:0]          DIV_MIN  = DIV_W'(MIN_DIV);
    localparam logic [DIV_W-1:0]          DIV_ONE  = DIV_W'(1);
    localparam logic [UART_BIT_IDX_W-1:0] IDX_ONE  = UART_BIT_IDX_W'(1);
    localparam logic [UART_BIT_IDX_W-1:0] IDX_LAST = UART_BIT_IDX_W'(UART_DATA_BITS - 1);

    uart_rx_state_e state_q;
    uart_rx_state_e state_d;

    logic                      rx_s;
    logic                      prev_rx;
    logic [DIV_W-1:0]          div_clamp;
    logic [DIV_W-1:0]          div_l;
    logic [DIV_W-1:0]          cnt;
    logic [UART_BIT_IDX_W-1:0] bit_idx;
    logic [UART_DATA_BITS-1:0] shreg;

    logic start_edge;
    logic expired;
    logic last_bit;
    logic arm;
    logic start_ok;
    logic shift_en;
    logic stop_good;
    logic stop_bad;
    logic take;
    logic pop;

    carbon_sync2 #(
        .RESET_VAL (1'b1)
    ) u_rx_sync (
        .clk (clk),
        .rst (rst),
        .d   (rx_in),
        .q   (rx_s)
    );

    assign start_edge = prev_rx && !rx_s;
    assign expired    = (cnt == '0);
    assign last_bit   = (bit_idx == IDX_LAST);
    assign div_clamp  = (baud_div < DIV_MIN) ? DIV_MIN : baud_div;

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic; dropping enable abandons whatever frame is in flight
    // ------------------------------------------------------------------
    // NOTE: state_d gets a default before the case so no path can infer a latch.
    always_comb begin
        state_d = state_q;
        if (!enable) begin
            state_d = IDLE;
        end else begin
            unique case (state_q)
                IDLE:     if (start_edge) state_d = START;
                START:    if (expired) state_d = rx_s ? IDLE : DATA;
                DATA:     if (expired && last_bit) state_d = STOP;
                STOP:     if (expired) state_d = rx_s ? IDLE : BRK_WAIT;
                BRK_WAIT: if (rx_s) state_d = IDLE;
                default:  state_d = IDLE;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Output / strobe decode
    // ------------------------------------------------------------------
    always_comb begin
        busy      = (state_q != IDLE);
        arm       = 1'b0;
        start_ok  = 1'b0;
        shift_en  = 1'b0;
        stop_good = 1'b0;
        stop_bad  = 1'b0;
        if (enable) begin
            unique case (state_q)
                IDLE:     arm       = start_edge;
                START:    start_ok  = expired && !rx_s;
                DATA:     shift_en  = expired;
                STOP: begin
                    stop_good = expired && rx_s;
                    stop_bad  = expired && !rx_s;
                end
                BRK_WAIT: ;
                default:  ;
            endcase
        end
    end

    // A byte is accepted if the holding register is empty or drains this cycle.
    assign pop  = rx_valid && rx_ready;
    assign take = stop_good && (!rx_valid || rx_ready);

    // ------------------------------------------------------------------
    // Bit timing and deserializer
    // ------------------------------------------------------------------
    // NOTE: the datapath is reset too, so a reset mid-frame cannot leak a stale partial byte.
    always_ff @(posedge clk) begin
        if (rst) begin
            prev_rx <= 1'b1;
            div_l   <= DIV_MIN;
            cnt     <= '0;
            bit_idx <= '0;
            shreg   <= '0;
        end else begin
            prev_rx <= rx_s;

            if (arm) begin
                div_l <= div_clamp;
                cnt   <= (div_clamp >> 1) - DIV_ONE;
            end else if (start_ok || shift_en) begin
                cnt <= div_l - DIV_ONE;
            end else if (!expired) begin
                cnt <= cnt - DIV_ONE;
            end

            if (start_ok) begin
                bit_idx <= '0;
            end else if (shift_en) begin
                bit_idx <= bit_idx + IDX_ONE;
                shreg   <= {rx_s, shreg[UART_DATA_BITS-1:1]};
            end
        end
    end

    // ------------------------------------------------------------------
    // Holding register and error pulses
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_valid    <= 1'b0;
            rx_data     <= '0;
            frame_err   <= 1'b0;
            overrun_err <= 1'b0;
        end else begin
            frame_err   <= stop_bad;
            overrun_err <= stop_good && !take;

            if (take) begin
                rx_valid <= 1'b1;
                rx_data  <= shreg;
            end else if (pop) begin
                rx_valid <= 1'b0;
            end
        end
    end

endmodule
